ib_lut_page_loader: RTL and testbench

Iteration-update sequencer for the IB-VNU/DNU LUT RAMs. It accepts a stream of LUT words for the next decoding iteration and writes them page by page into the inactive half of the dual-half LUT RAM through the page write port. It then swaps the active half (`read_addr_offset`) at the iteration boundary. The block sits between the LUT-set source and every `vnu*_f*` / decision-node RAM write port, and owns `page_addr_ram`, `ram_write_data_1` and `ib_ram_we`.

---
 rtl/ib_lut_page_loader.sv | 157 +++++++++++++++
 tb/tb_ib_lut_page_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ib_lut_page_loader.sv
// Iteration-update sequencer for the IB LUT RAMs: streams the next LUT set into
// the inactive RAM half page by page, then flips the active half on request.
module ib_lut_page_loader #(
  parameter int ENTRY_ADDR    = 7,
  parameter int BANK_NUM      = 2,
  parameter int LUT_PORT_SIZE = 4,
  parameter int PAGE_NUM      = 64,
  parameter int ITER_WIDTH    = 5
) (
  input  logic                              write_clk,
  input  logic                              rst,
  input  logic                              load_start,
  input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] lut_data,
  input  logic                              lut_valid,
  output logic                              lut_ready,
  input  logic                              swap_req,
  output logic [ENTRY_ADDR-1:0]             page_addr_ram,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_1,
  output logic                              ib_ram_we,
  output logic                              read_addr_offset,
  output logic                              busy,
  output logic                              load_done,
  output logic                              swap_ack,
  output logic                              swap_miss,
  output logic [ITER_WIDTH-1:0]             iter_cnt
);

  localparam int PAGE_W = ENTRY_ADDR - 1;
  localparam int DATA_W = LUT_PORT_SIZE * BANK_NUM;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    LOADED = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [PAGE_W-1:0]   page_cnt;
  logic [PAGE_W-1:0]   page_cnt_next;
  logic                beat;
  logic                last_beat;
  logic                swap_take;
  logic                swap_reject;

  // State register: FSM state and the page pointer into the inactive half.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      state    <= IDLE;
      page_cnt <= {PAGE_W{1'b0}};
    end else begin
      state    <= state_next;
      page_cnt <= page_cnt_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next    = state;
    page_cnt_next = page_cnt;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_next    = LOAD;
          page_cnt_next = {PAGE_W{1'b0}};
        end else begin
          state_next    = IDLE;
        end
      end
      LOAD: begin
        if (last_beat) begin
          state_next    = LOADED;
          page_cnt_next = {PAGE_W{1'b0}};
        end else if (beat) begin
          page_cnt_next = page_cnt + PAGE_W'(1);
        end else begin
          page_cnt_next = page_cnt;
        end
      end
      LOADED: begin
        // A start arriving with the swap chains straight into the next load.
        if (swap_req && load_start) begin
          state_next    = LOAD;
          page_cnt_next = {PAGE_W{1'b0}};
        end else if (swap_req) begin
          state_next    = IDLE;
        end else begin
          state_next    = LOADED;
        end
      end
      default: begin
        state_next    = IDLE;
        page_cnt_next = {PAGE_W{1'b0}};
      end
    endcase
  end

  // Output decode feeding the registered outputs.
  always_comb begin
    beat        = 1'b0;
    last_beat   = 1'b0;
    swap_take   = 1'b0;
    swap_reject = 1'b0;
    if (state == LOAD) begin
      beat      = lut_valid;
      last_beat = lut_valid && (page_cnt == PAGE_W'(PAGE_NUM - 1));
    end else begin
      beat      = 1'b0;
      last_beat = 1'b0;
    end
    if (state == LOADED) begin
      swap_take   = swap_req;
      swap_reject = 1'b0;
    end else begin
      swap_take   = 1'b0;
      swap_reject = swap_req;
    end
  end

  // Registered write port, handshake, half select and status pulses.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      page_addr_ram    <= {ENTRY_ADDR{1'b0}};
      ram_write_data_1 <= {DATA_W{1'b0}};
      ib_ram_we        <= 1'b0;
      read_addr_offset <= 1'b0;
      iter_cnt         <= {ITER_WIDTH{1'b0}};
      lut_ready        <= 1'b0;
      busy             <= 1'b0;
      load_done        <= 1'b0;
      swap_ack         <= 1'b0;
      swap_miss        <= 1'b0;
    end else begin
      ib_ram_we <= beat;
      if (beat) begin
        page_addr_ram    <= {~read_addr_offset, page_cnt};
        ram_write_data_1 <= lut_data;
      end else begin
        page_addr_ram    <= page_addr_ram;
        ram_write_data_1 <= ram_write_data_1;
      end
      if (swap_take) begin
        read_addr_offset <= ~read_addr_offset;
        iter_cnt         <= iter_cnt + ITER_WIDTH'(1);
      end else begin
        read_addr_offset <= read_addr_offset;
        iter_cnt         <= iter_cnt;
      end
      lut_ready <= (state_next == LOAD);
      busy      <= (state_next == LOAD);
      load_done <= last_beat;
      swap_ack  <= swap_take;
      swap_miss <= swap_reject;
    end
  end

endmodule

// File: tb/tb_ib_lut_page_loader.sv
// Directed bench for ib_lut_page_loader: a transaction-level model is compared
// against every output each cycle, plus hand-computed literal expectations.
module tb_ib_lut_page_loader;

  localparam int ENTRY_ADDR = 7;
  localparam int PAGE_NUM   = 64;
  localparam int ITER_WIDTH = 5;
  localparam int ITER_MOD   = 1 << ITER_WIDTH;

  logic       write_clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0;
  logic [7:0] lut_data = 8'd0;
  logic       lut_valid = 1'b0;
  logic       swap_req = 1'b0;
  logic       lut_ready;
  logic [6:0] page_addr_ram;
  logic [7:0] ram_write_data_1;
  logic       ib_ram_we;
  logic       read_addr_offset;
  logic       busy;
  logic       load_done;
  logic       swap_ack;
  logic       swap_miss;
  logic [4:0] iter_cnt;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  ib_lut_page_loader #(
    .ENTRY_ADDR(ENTRY_ADDR), .BANK_NUM(2), .LUT_PORT_SIZE(4),
    .PAGE_NUM(PAGE_NUM), .ITER_WIDTH(ITER_WIDTH)
  ) dut (
    .write_clk(write_clk), .rst(rst), .load_start(load_start),
    .lut_data(lut_data), .lut_valid(lut_valid), .lut_ready(lut_ready),
    .swap_req(swap_req), .page_addr_ram(page_addr_ram),
    .ram_write_data_1(ram_write_data_1), .ib_ram_we(ib_ram_we),
    .read_addr_offset(read_addr_offset), .busy(busy), .load_done(load_done),
    .swap_ack(swap_ack), .swap_miss(swap_miss), .iter_cnt(iter_cnt)
  );

  always #5 write_clk = ~write_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 = nothing pending, 1 = loading, 2 = a full set waits for swap
  typedef struct {
    int mode; int pages; bit off; int iter;
    bit we; int addr; int data; bit done; bit ack; bit miss;
  } model_t;

  model_t m;

  function automatic model_t step(model_t s, bit r, bit ls, bit lv, bit sr, int d);
    model_t n;
    n = s;
    if (r) begin
      n.mode = 0; n.pages = 0; n.off = 1'b0; n.iter = 0;
      n.we = 1'b0; n.addr = 0; n.data = 0; n.done = 1'b0; n.ack = 1'b0; n.miss = 1'b0;
      return n;
    end
    n.we   = (s.mode == 1) && lv;
    n.done = 1'b0;
    n.ack  = 1'b0;
    n.miss = sr && (s.mode != 2);
    if (n.we) begin
      // inactive half base: PAGE_NUM-aligned half opposite the active one
      n.addr  = (s.off ? 0 : (1 << (ENTRY_ADDR - 1))) + s.pages;
      n.data  = d;
      n.pages = s.pages + 1;
      if (n.pages == PAGE_NUM) begin
        n.mode = 2; n.done = 1'b1; n.pages = 0;
      end
    end else if (s.mode == 0 && ls) begin
      n.mode = 1; n.pages = 0;
    end else if (s.mode == 2 && sr) begin
      n.off  = ~s.off;
      n.iter = (s.iter + 1) % ITER_MOD;
      n.ack  = 1'b1;
      n.mode = ls ? 1 : 0;
      n.pages = 0;
    end
    return n;
  endfunction

  always @(posedge write_clk) m <= step(m, rst, load_start, lut_valid, swap_req, int'(lut_data));

  // Per-cycle comparison against the model
  always @(negedge write_clk) begin
    if (cmp_en) begin
      chk("we", ib_ram_we, m.we);
      chk("addr", page_addr_ram, m.addr);
      chk("data", ram_write_data_1, m.data);
      chk("ready", lut_ready, m.mode == 1);
      chk("busy", busy, m.mode == 1);
      chk("offset", read_addr_offset, m.off);
      chk("iter", iter_cnt, m.iter);
      chk("done", load_done, m.done);
      chk("ack", swap_ack, m.ack);
      chk("miss", swap_miss, m.miss);
    end
  end

  int wcount = 0, first_addr = -1, last_addr = -1, last_data = -1, done_addr = -1;

  always @(negedge write_clk) begin
    if (ib_ram_we === 1'b1) begin
      if (wcount == 0) first_addr = page_addr_ram;
      wcount++;
      last_addr = page_addr_ram;
      last_data = ram_write_data_1;
      if (load_done === 1'b1) done_addr = page_addr_ram;
    end
  end

  task automatic clr_cnt();
    wcount = 0; first_addr = -1; last_addr = -1; last_data = -1; done_addr = -1;
  endtask

  task automatic tick();
    @(negedge write_clk);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  task automatic feed(input int n, input int gap, input int swap_at, input bit off_exp);
    for (int i = 0; i < n; i++) begin
      lut_valid = 1'b1;
      lut_data  = 8'(i);
      swap_req  = (i == swap_at);
      tick();
      swap_req  = 1'b0;
      if (i == swap_at) begin
        chk("early_swap_miss", swap_miss, 1'b1);
        chk("early_swap_offset", read_addr_offset, off_exp);
      end
      if (gap != 0) begin
        lut_valid = 1'b0;
        tick();
      end
    end
    lut_valid = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_we", ib_ram_we, 1'b0);
    chk("rst_ready", lut_ready, 1'b0);
    chk("rst_iter", iter_cnt, 5'd0);

    // Basic back-to-back load into the upper half
    clr_cnt();
    start_load();
    chk("ready_after_start", lut_ready, 1'b1);
    feed(64, 0, -1, 1'b0);
    repeat (3) tick();
    chk("basic_writes", wcount, 64);
    chk("basic_first_addr", first_addr, 64);
    chk("basic_last_addr", last_addr, 127);
    chk("basic_last_data", last_data, 63);
    chk("basic_done_addr", done_addr, 127);
    chk("basic_ready_low", lut_ready, 1'b0);
    chk("basic_busy_low", busy, 1'b0);

    // Swap, then a throttled load into the lower half
    pulse_swap();
    chk("swap_offset", read_addr_offset, 1'b1);
    chk("swap_ack", swap_ack, 1'b1);
    chk("swap_iter", iter_cnt, 5'd1);
    clr_cnt();
    start_load();
    feed(64, 1, -1, 1'b1);
    repeat (3) tick();
    chk("throttle_writes", wcount, 64);
    chk("throttle_first_addr", first_addr, 0);
    chk("throttle_last_addr", last_addr, 63);
    chk("throttle_done_addr", done_addr, 63);

    // Early swap during a load is rejected and the load completes
    pulse_swap();
    chk("swap2_offset", read_addr_offset, 1'b0);
    clr_cnt();
    start_load();
    feed(64, 0, 10, 1'b0);
    repeat (3) tick();
    chk("early_writes", wcount, 64);
    chk("early_done_addr", done_addr, 127);

    // Simultaneous swap and start from LOADED with offset 0
    swap_req = 1'b1;
    load_start = 1'b1;
    tick();
    swap_req = 1'b0;
    load_start = 1'b0;
    chk("sim_offset", read_addr_offset, 1'b1);
    chk("sim_busy", busy, 1'b1);
    chk("sim_ack", swap_ack, 1'b1);
    clr_cnt();
    feed(30, 0, -1, 1'b1);
    repeat (2) tick();
    chk("sim_first_addr", first_addr, 0);
    chk("sim_partial_writes", wcount, 30);

    // Reset at page 30 discards the partial set
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_offset", read_addr_offset, 1'b0);
    chk("mid_rst_iter", iter_cnt, 5'd0);
    chk("mid_rst_addr", page_addr_ram, 7'd0);
    pulse_swap();
    chk("idle_swap_miss", swap_miss, 1'b1);
    chk("idle_swap_offset", read_addr_offset, 1'b0);
    clr_cnt();
    start_load();
    feed(64, 0, 5, 1'b0);
    repeat (3) tick();
    chk("restart_first_addr", first_addr, 64);
    chk("restart_writes", wcount, 64);

    // Iteration counter wrap over 32 swaps
    for (int k = 0; k < 32; k++) begin
      pulse_swap();
      if (k == 30) chk("iter_31", iter_cnt, 5'd31);
      start_load();
      feed(64, 0, -1, read_addr_offset);
      repeat (2) tick();
    end
    chk("iter_wrap", iter_cnt, 5'd0);
    chk("iter_wrap_offset", read_addr_offset, 1'b0);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
